// File: rtl/if_fetch_pc.sv
// Fetch-stage PC and IF/ID pipeline register with stall handling and ID-resolved redirects.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the slot instruction on a redirect; otherwise a bubble is loaded.
module if_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned N        = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F,
  input  logic        redirect_D,
  input  logic [31:0] target_D,
  input  logic [N:0]  Instruction_F,
  output logic [N:0]  I_addr,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        valid_D,
  output logic        misalign_D
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_PEND = 1'b1;

  logic        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_mis_q, pend_mis_d;
  logic        mis_q, mis_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misd_q, misd_d;

  logic        take;
  logic [31:0] tgt_aligned;
  logic        tgt_mis;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_mis_d = pend_mis_q;
    mis_d      = mis_q;
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misd_d     = misd_q;
    take       = (state_q == ST_PEND) || redirect_D;
    // A pending redirect takes precedence over a fresh pulse on the release edge.
    tgt_aligned = (state_q == ST_PEND) ? pend_tgt_q : {target_D[31:2], 2'b00};
    tgt_mis     = (state_q == ST_PEND) ? pend_mis_q : (|target_D[1:0]);

    if (stall_F) begin
      if (redirect_D) begin
        pend_tgt_d = {target_D[31:2], 2'b00};
        pend_mis_d = |target_D[1:0];
        state_d    = ST_PEND;
      end
    end else begin
      pcd_d = pc_q;
      pc4_d = pc_plus4;
      if (take) begin
        pc_d    = tgt_aligned;
        mis_d   = tgt_mis;
        state_d = ST_RUN;
`ifdef BRANCH_DELAY_SLOT_EN
        instr_d = 32'(Instruction_F);
        valid_d = 1'b1;
        misd_d  = mis_q;
`else
        instr_d = '0;
        valid_d = 1'b0;
        misd_d  = 1'b0;
`endif
      end else begin
        pc_d    = pc_plus4;
        instr_d = 32'(Instruction_F);
        valid_d = 1'b1;
        misd_d  = mis_q;
        mis_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_mis_q <= 1'b0;
      mis_q      <= 1'b0;
      instr_q    <= '0;
      pcd_q      <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      misd_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_mis_q <= pend_mis_d;
      mis_q      <= mis_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misd_q     <= misd_d;
    end
  end

  assign I_addr     = pc_q[N:0];
  assign Instr_D    = instr_q;
  assign PC_D       = pcd_q;
  assign PC4_D      = pc4_q;
  assign valid_D    = valid_q;
  assign misalign_D = misd_q;

endmodule

// File: tb/tb_if_fetch_pc.sv
// Bench for if_fetch_pc: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_if_fetch_pc;

  logic        clk = 1'b0;
  logic        rst, stall_F, redirect_D;
  logic [31:0] target_D;
  logic [31:0] Instruction_F;
  logic [31:0] I_addr, Instr_D, PC_D, PC4_D;
  logic        valid_D, misalign_D;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  bit          chk_en = 1'b0;

  // model state
  logic [31:0] m_pc, m_ptgt, m_instr, m_pcd, m_pc4;
  bit          m_pend, m_pmis, m_flag, m_valid, m_mis;

  if_fetch_pc #(.RESET_PC(32'h0000_0000), .N(31)) dut (
    .clk(clk), .rst(rst), .stall_F(stall_F), .redirect_D(redirect_D),
    .target_D(target_D), .Instruction_F(Instruction_F), .I_addr(I_addr),
    .Instr_D(Instr_D), .PC_D(PC_D), .PC4_D(PC4_D), .valid_D(valid_D),
    .misalign_D(misalign_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign Instruction_F = rom(I_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model of one clock edge.
  task automatic model_edge(input bit r, input bit s, input bit rd, input logic [31:0] t);
    logic [31:0] ins;
    ins = rom(m_pc);
    if (r) begin
      m_pc = 32'h0; m_pend = 0; m_ptgt = 0; m_pmis = 0; m_flag = 0;
      m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
    end else if (s) begin
      if (rd) begin
        m_pend = 1; m_ptgt = t & ~32'h3; m_pmis = (t[1:0] != 2'b00);
      end
    end else begin
      m_pcd = m_pc;
      m_pc4 = m_pc + 32'd4;
      if (m_pend || rd) begin
`ifdef BRANCH_DELAY_SLOT_EN
        m_instr = ins; m_valid = 1; m_mis = m_flag;
`else
        m_instr = 0; m_valid = 0; m_mis = 0;
`endif
        m_pc   = m_pend ? m_ptgt : (t & ~32'h3);
        m_flag = m_pend ? m_pmis : (t[1:0] != 2'b00);
        m_pend = 0;
      end else begin
        m_instr = ins; m_valid = 1; m_mis = m_flag; m_flag = 0;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] t);
    rst = r; stall_F = s; redirect_D = rd; target_D = t;
    @(posedge clk);
    model_edge(r, s, rd, t);
    #2;
  endtask

  // Single compare process: every negedge once checking is enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("I_addr", I_addr, m_pc);
      chk("Instr_D", Instr_D, m_instr);
      chk("PC_D", PC_D, m_pcd);
      chk("PC4_D", PC4_D, m_pc4);
      chk("valid_D", {31'b0, valid_D}, {31'b0, m_valid});
      chk("misalign_D", {31'b0, misalign_D}, {31'b0, m_mis});
    end
  end

  initial begin
    logic [31:0] t;
    bit s, rd, r;
    m_pc = 0; m_ptgt = 0; m_instr = 0; m_pcd = 0; m_pc4 = 0;
    m_pend = 0; m_pmis = 0; m_flag = 0; m_valid = 0; m_mis = 0;

    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_I_addr", I_addr, 32'h0);
    chk("rst_valid", {31'b0, valid_D}, 32'h0);
    chk("rst_Instr", Instr_D, 32'h0);

    cyc(0, 0, 0, 0);
    chk("e1_Instr", Instr_D, rom(32'h0));
    chk("e1_PC_D", PC_D, 32'h0);
    chk("e1_PC4_D", PC4_D, 32'h4);
    chk("e1_valid", {31'b0, valid_D}, 32'h1);
    chk("e1_I_addr", I_addr, 32'h4);
    cyc(0, 0, 0, 0);
    chk("e2_I_addr", I_addr, 32'h8);

    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("stall_I_addr", I_addr, 32'h8);
    chk("stall_PC_D", PC_D, 32'h4);
    cyc(0, 0, 0, 0);
    chk("rel_PC_D", PC_D, 32'h8);
    chk("rel_I_addr", I_addr, 32'hC);
    cyc(0, 0, 0, 0);
    chk("pre_br_I_addr", I_addr, 32'h10);

    cyc(0, 0, 1, 32'h40);
    chk("br_I_addr", I_addr, 32'h40);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("br_slot_Instr", Instr_D, rom(32'h10));
    chk("br_slot_valid", {31'b0, valid_D}, 32'h1);
`else
    chk("br_slot_Instr", Instr_D, 32'h0);
    chk("br_slot_valid", {31'b0, valid_D}, 32'h0);
`endif
    cyc(0, 0, 0, 0);
    chk("br_tgt_Instr", Instr_D, rom(32'h40));
    chk("br_tgt_PC_D", PC_D, 32'h40);

    cyc(0, 1, 1, 32'h80);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h90);
    chk("pend_I_addr", I_addr, 32'h44);
    cyc(0, 0, 0, 0);
    chk("pend_rel_I_addr", I_addr, 32'h90);
    cyc(0, 0, 0, 0);
    chk("pend_next_I_addr", I_addr, 32'h94);

    cyc(0, 0, 1, 32'h42);
    chk("mis_I_addr", I_addr, 32'h40);
    chk("mis_slot", {31'b0, misalign_D}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("mis_set", {31'b0, misalign_D}, 32'h1);
    chk("mis_PC_D", PC_D, 32'h40);
    cyc(0, 0, 0, 0);
    chk("mis_clear", {31'b0, misalign_D}, 32'h0);

    cyc(0, 1, 1, 32'h100);
    cyc(1, 0, 0, 0);
    chk("rst_pend_I_addr", I_addr, 32'h0);
    chk("rst_pend_valid", {31'b0, valid_D}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("rst_pend_after", I_addr, 32'h4);
    cyc(0, 0, 0, 0);
    chk("rst_pend_after2", I_addr, 32'h8);

    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) < 2);
      s  = ($urandom_range(99) < 30);
      rd = ($urandom_range(99) < 20);
      t  = $urandom;
      if (i % 97 == 0) t = 32'hFFFF_FFF8 | {30'b0, t[1:0]};
      cyc(r, s, rd, t);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_pc.md
# if_fetch_pc

Fetch-stage program counter and IF/ID pipeline register for the 5-stage MIPS core. Drives `I_addr` into the instruction ROM, accepts `Instruction_F` (combinational read) in the same cycle, and latches instruction, PC and PC+4 into the IF/ID register for decode. Handles stalls, branch/jump redirects resolved in ID, and redirects that arrive during a stall.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall_F`  in  1  hold PC and IF/ID contents this edge.
- `redirect_D`  in  1  one-cycle pulse: branch/jump taken in ID.
- `target_D`  in  32  redirect target, valid with `redirect_D`.
- `Instruction_F`  in  `N+1`  instruction word read at `I_addr`.
- `I_addr`  out  `N+1`  current fetch PC, bits [1:0] always 0.
- `Instr_D`  out  32  IF/ID instruction.
- `PC_D`  out  32  PC of `Instr_D`.
- `PC4_D`  out  32  `PC_D + 4`.
- `valid_D`  out  1  `Instr_D` is a real instruction, not a bubble.
- `misalign_D`  out  1  `Instr_D` was fetched from a redirect target with nonzero [1:0].

## Operation
- PC register `pc_F`; `I_addr = pc_F` combinationally.
- FSM states: RUN, PEND. Pending register `pend_tgt` (32) and `pend_mis` (1).
- Edge priority: `rst` > `stall_F` > redirect (RUN with `redirect_D`, or PEND) > sequential.
- `rst`: `pc_F = RESET_PC`, state RUN. `Instr_D`, `PC_D`, `PC4_D`, `valid_D`, `misalign_D`, `pend_tgt`, and `pend_mis` all become 0.
- RUN, `stall_F=1`, `redirect_D=0`: all registers hold.
- RUN, `stall_F=1`, `redirect_D=1`: capture `{target_D[31:2],2'b00}` into `pend_tgt`, capture `|target_D[1:0]` into `pend_mis`, go to PEND. PC and IF/ID hold.
- PEND, `stall_F=1`: hold. If `redirect_D=1`, the new target overwrites `pend_tgt`/`pend_mis`.
- RUN with `redirect_D=1`, or PEND, when `stall_F=0`:
  - `pc_F <= target` (aligned). Target is `target_D` in RUN, `pend_tgt` in PEND.
  - A misalign flag register is set from the target's low bits. It travels to `misalign_D` with the instruction fetched at the new PC.
  - The instruction currently in IF (the slot after the branch) is handled per Configuration.
  - State returns to RUN.
- Sequential, no stall: `pc_F <= pc_F + 4` (wraps modulo 2^32).
  - `Instr_D <= Instruction_F`, `PC_D <= pc_F`, `PC4_D <= pc_F + 4`, `valid_D <= 1`.
  - `misalign_D <=` misalign flag, then the flag clears.
- A bubble is loaded as: `Instr_D = 0` (sll nop), `valid_D = 0`, `misalign_D = 0`. `PC_D` and `PC4_D` still take the IF PC.

## Timing
- Fetch-to-decode latency: one edge. The instruction at `I_addr` in cycle n appears on `Instr_D` after edge n.
- `Instruction_F` must settle within the same cycle; no memory wait states.
- Redirect without stall: the target appears on `I_addr` in the cycle after the `redirect_D` edge. Its instruction reaches `Instr_D` one edge later.
- Redirect during stall: the target appears on `I_addr` in the cycle after the first edge with `stall_F=0`. A redirect is never lost.
- Reset mid-PEND discards the pending target.

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined (MIPS delay-slot semantics):
  - On the redirect edge, the IF instruction is latched into IF/ID with `valid_D=1`.
  - This applies whether the redirect came from RUN or from PEND.
- Not defined:
  - On the redirect edge, IF/ID loads a bubble. The slot instruction is discarded.

## Test plan
- Reset, then 3 free-running edges: `I_addr` runs 0x0, 0x4, 0x8, 0xC. `Instr_D` equals the ROM word at 0x0 after edge 1, with `PC_D=0x0`, `PC4_D=0x4`, `valid_D=1`. Before edge 1, `valid_D=0`.
- `stall_F` high for 2 edges at PC 0x8: `I_addr` and IF/ID unchanged both edges. After release, the next edge gives `PC_D=0x8` and `I_addr=0xC`.
- `redirect_D` pulse with `target_D=0x40` at PC 0x10: next `I_addr=0x40`. `Instr_D` holds the word from 0x10 with `valid_D=1` if `BRANCH_DELAY_SLOT_EN`, else 0 with `valid_D=0`.
- Redirect to 0x80 while stalled, then to 0x90 while still stalled, then release: `I_addr` goes directly to 0x90, and 0x80 is never fetched.
- Redirect to 0x42: `I_addr=0x40`, and the following IF/ID load has `misalign_D=1`. The next sequential load has `misalign_D=0`.
- Assert `rst` while in PEND with `pend_tgt=0x100`: `I_addr=RESET_PC`, `valid_D=0`, and 0x100 is never fetched afterwards.
